// File: rtl/sfx_sequencer.sv
// Event-driven sound-effect sequencer: picks the highest-priority game event and plays its melody.
// Optional build macro SFX_LOSE_LOOP_EN: the lose melody repeats until reset instead of playing once.
module sfx_sequencer #(
   parameter int unsigned NOTE_TICKS = 5_000_000,
   parameter int unsigned GAP_TICKS  = 500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ev_key,
   input  logic        ev_land,
   input  logic        ev_row,
   input  logic        ev_lose,
   output logic [19:0] freq,
   output logic        write_en,
   output logic        busy,
   output logic [1:0]  sfx_id
);

   localparam int unsigned FREQ_W    = 20;
   localparam int unsigned MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int unsigned CNT_W     = $clog2(MAX_TICKS);
   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [1:0]          idx, idx_d;
   logic [1:0]          id_d;
   logic [3:0]          ev_q, ev_prev, trig;
   logic                trig_any, preempt, has_next, loop_last;
   logic [1:0]          trig_id;
   logic [FREQ_W-1:0]   freq_d;
   logic                write_en_d, busy_d;

   // Melody ROM of half-periods; a zero entry terminates the melody.
   function automatic logic [FREQ_W-1:0] rom_note(input logic [1:0] id, input logic [1:0] n);
      case ({id, n})
         4'b00_00: rom_note = 20'd56818;
         4'b01_00: rom_note = 20'd113636;
         4'b01_01: rom_note = 20'd75843;
         4'b10_00: rom_note = 20'd47778;
         4'b10_01: rom_note = 20'd37922;
         4'b10_10: rom_note = 20'd31888;
         4'b11_00: rom_note = 20'd75843;
         4'b11_01: rom_note = 20'd95602;
         4'b11_10: rom_note = 20'd113636;
         4'b11_11: rom_note = 20'd151515;
         default:  rom_note = '0;
      endcase
   endfunction

   // Rising-edge detect on the registered events, then fixed priority lose > row > land > key.
   always_comb begin
      trig     = ev_q & ~ev_prev;
      trig_any = |trig;
      if (trig[3])      trig_id = 2'd3;
      else if (trig[2]) trig_id = 2'd2;
      else if (trig[1]) trig_id = 2'd1;
      else              trig_id = 2'd0;
      preempt  = trig_any && (trig_id > sfx_id);
      has_next = (idx != 2'd3) && (rom_note(sfx_id, 2'(idx + 2'd1)) != '0);
`ifdef SFX_LOSE_LOOP_EN
      loop_last = (sfx_id == 2'd3);
`else
      loop_last = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         ev_q     <= '0;
         ev_prev  <= '0;
         freq     <= '0;
         write_en <= 1'b0;
         busy     <= 1'b0;
         sfx_id   <= '0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         idx      <= idx_d;
         ev_q     <= {ev_lose, ev_row, ev_land, ev_key};
         ev_prev  <= ev_q;
         freq     <= freq_d;
         write_en <= write_en_d;
         busy     <= busy_d;
         sfx_id   <= id_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      id_d    = sfx_id;
      case (state)
         S_IDLE: begin
            if (trig_any) begin
               state_d = S_NOTE;
               id_d    = trig_id;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         S_NOTE: begin
            if (preempt) begin
               id_d  = trig_id;
               idx_d = '0;
               cnt_d = '0;
            end else if (cnt == NOTE_LAST) begin
               cnt_d = '0;
               if (has_next || loop_last) begin
                  state_d = S_GAP;
               end else if (trig_any) begin
                  // Finishing melody: any trigger starts immediately, no idle cycle.
                  id_d  = trig_id;
                  idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = CNT_W'(cnt + 1'b1);
            end
         end
         S_GAP: begin
            if (preempt) begin
               state_d = S_NOTE;
               id_d    = trig_id;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt == GAP_LAST) begin
               state_d = S_NOTE;
               idx_d   = 2'(idx + 2'd1);
               cnt_d   = '0;
            end else begin
               cnt_d = CNT_W'(cnt + 1'b1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next output values; the gap keeps the last note's half-period on freq.
   always_comb begin
      freq_d     = '0;
      write_en_d = (state_d == S_NOTE);
      busy_d     = (state_d != S_IDLE);
      case (state_d)
         S_NOTE:  freq_d = rom_note(id_d, idx_d);
         S_GAP:   freq_d = freq;
         default: freq_d = '0;
      endcase
   end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed self-checking bench for sfx_sequencer with NOTE_TICKS=8, GAP_TICKS=2.
module tb_sfx_sequencer;

   logic        clk;
   logic        reset;
   logic        ev_key, ev_land, ev_row, ev_lose;
   logic [19:0] freq;
   logic        write_en, busy;
   logic [1:0]  sfx_id;

   int checks = 0;
   int errors = 0;

   sfx_sequencer #(.NOTE_TICKS(8), .GAP_TICKS(2)) dut (
      .clk(clk), .reset(reset),
      .ev_key(ev_key), .ev_land(ev_land), .ev_row(ev_row), .ev_lose(ev_lose),
      .freq(freq), .write_en(write_en), .busy(busy), .sfx_id(sfx_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      ev_key = 0; ev_land = 0; ev_row = 0; ev_lose = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [23:0] exp;
      reset = 1'b0;
      ev_key = 1; ev_land = 1; ev_row = 1; ev_lose = 1;
      @(negedge clk);
      @(negedge clk);
      exp = '0;
      checks++;
      if ({freq, write_en, busy, sfx_id} !== exp) begin
         errors++; $display("FAIL reset_state: got %h want %h", {freq, write_en, busy, sfx_id}, exp);
      end
   endtask

   task automatic test_key();
      logic [23:0] exp;
      do_reset();
      ev_key = 1;
      @(negedge clk); ev_key = 0;
      exp = '0; checks++;
      if ({freq, write_en, busy, sfx_id} !== exp) begin
         errors++; $display("FAIL key_latency: got %h want %h", {freq, write_en, busy, sfx_id}, exp);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp = {20'd56818, 1'b1, 1'b1, 2'd0}; checks++;
         if ({freq, write_en, busy, sfx_id} !== exp) begin
            errors++; $display("FAIL key_note c%0d: got %h want %h", c, {freq, write_en, busy, sfx_id}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if ({freq, write_en, busy} !== 22'd0) begin
         errors++; $display("FAIL key_end: got %h want 0", {freq, write_en, busy});
      end
   endtask

   task automatic test_row();
      logic [23:0] exp;
      logic [19:0] nt [3];
      nt[0] = 20'd47778; nt[1] = 20'd37922; nt[2] = 20'd31888;
      do_reset();
      ev_row = 1;
      @(negedge clk); ev_row = 0;
      for (int n = 0; n < 3; n++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (n == 0 && c == 3) ev_land = 0;
            exp = {nt[n], 1'b1, 1'b1, 2'd2}; checks++;
            if ({freq, write_en, busy, sfx_id} !== exp) begin
               errors++; $display("FAIL row_note n%0d c%0d: got %h want %h", n, c, {freq, write_en, busy, sfx_id}, exp);
            end
            if (n == 0 && c == 2) ev_land = 1;
         end
         if (n < 2) begin
            for (int g = 0; g < 2; g++) begin
               @(negedge clk);
               exp = {nt[n], 1'b0, 1'b1, 2'd2}; checks++;
               if ({freq, write_en, busy, sfx_id} !== exp) begin
                  errors++; $display("FAIL row_gap n%0d g%0d: got %h want %h", n, g, {freq, write_en, busy, sfx_id}, exp);
               end
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({freq, write_en, busy} !== 22'd0) begin
         errors++; $display("FAIL row_end: got %h want 0", {freq, write_en, busy});
      end
   endtask

   task automatic test_simultaneous();
      logic [23:0] exp;
      logic [19:0] nt [2];
      nt[0] = 20'd113636; nt[1] = 20'd75843;
      do_reset();
      ev_land = 1; ev_key = 1;
      @(negedge clk); ev_land = 0; ev_key = 0;
      for (int n = 0; n < 2; n++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = {nt[n], 1'b1, 1'b1, 2'd1}; checks++;
            if ({freq, write_en, busy, sfx_id} !== exp) begin
               errors++; $display("FAIL simul_note n%0d c%0d: got %h want %h", n, c, {freq, write_en, busy, sfx_id}, exp);
            end
         end
         if (n == 0) begin
            for (int g = 0; g < 2; g++) begin
               @(negedge clk);
               exp = {nt[0], 1'b0, 1'b1, 2'd1}; checks++;
               if ({freq, write_en, busy, sfx_id} !== exp) begin
                  errors++; $display("FAIL simul_gap g%0d: got %h want %h", g, {freq, write_en, busy, sfx_id}, exp);
               end
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({freq, write_en, busy} !== 22'd0) begin
         errors++; $display("FAIL simul_end: got %h want 0", {freq, write_en, busy});
      end
   endtask

   task automatic test_preempt();
      logic [23:0] exp;
      logic [19:0] ln [4];
      ln[0] = 20'd75843; ln[1] = 20'd95602; ln[2] = 20'd113636; ln[3] = 20'd151515;
      do_reset();
      ev_land = 1;
      @(negedge clk); ev_land = 0;
      for (int c = 0; c < 10; c++) @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 3) ev_lose = 0;
         exp = {20'd75843, 1'b1, 1'b1, 2'd1}; checks++;
         if ({freq, write_en, busy, sfx_id} !== exp) begin
            errors++; $display("FAIL land_note2 c%0d: got %h want %h", c, {freq, write_en, busy, sfx_id}, exp);
         end
         if (c == 2) ev_lose = 1;
      end
      for (int n = 0; n < 4; n++) begin
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (n == 1 && c == 1) ev_key = 0;
            exp = {ln[n], 1'b1, 1'b1, 2'd3}; checks++;
            if ({freq, write_en, busy, sfx_id} !== exp) begin
               errors++; $display("FAIL lose_note n%0d c%0d: got %h want %h", n, c, {freq, write_en, busy, sfx_id}, exp);
            end
            if (n == 1 && c == 0) ev_key = 1;
         end
         if (n < 3) begin
            for (int g = 0; g < 2; g++) begin
               @(negedge clk);
               exp = {ln[n], 1'b0, 1'b1, 2'd3}; checks++;
               if ({freq, write_en, busy, sfx_id} !== exp) begin
                  errors++; $display("FAIL lose_gap n%0d g%0d: got %h want %h", n, g, {freq, write_en, busy, sfx_id}, exp);
               end
            end
         end
      end
`ifdef SFX_LOSE_LOOP_EN
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         exp = {20'd151515, 1'b0, 1'b1, 2'd3}; checks++;
         if ({freq, write_en, busy, sfx_id} !== exp) begin
            errors++; $display("FAIL loop_gap g%0d: got %h want %h", g, {freq, write_en, busy, sfx_id}, exp);
         end
      end
      @(negedge clk);
      exp = {20'd75843, 1'b1, 1'b1, 2'd3}; checks++;
      if ({freq, write_en, busy, sfx_id} !== exp) begin
         errors++; $display("FAIL loop_restart: got %h want %h", {freq, write_en, busy, sfx_id}, exp);
      end
`else
      @(negedge clk);
      checks++;
      if ({freq, write_en, busy} !== 22'd0) begin
         errors++; $display("FAIL lose_end: got %h want 0", {freq, write_en, busy});
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [23:0] exp;
      do_reset();
      ev_key = 1;
      @(negedge clk); ev_key = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c == 7) ev_key = 0;
         exp = {20'd56818, 1'b1, 1'b1, 2'd0}; checks++;
         if ({freq, write_en, busy, sfx_id} !== exp) begin
            errors++; $display("FAIL b2b_note c%0d: got %h want %h", c, {freq, write_en, busy, sfx_id}, exp);
         end
         if (c == 6) ev_key = 1;
      end
      @(negedge clk);
      checks++;
      if ({freq, write_en, busy} !== 22'd0) begin
         errors++; $display("FAIL b2b_end: got %h want 0", {freq, write_en, busy});
      end
   endtask

   task automatic test_hold_reset();
      logic [23:0] exp;
      do_reset();
      ev_key = 1;
      for (int t = 1; t <= 100; t++) begin
         @(negedge clk);
         exp = (t >= 2 && t <= 9) ? {20'd56818, 1'b1, 1'b1, 2'd0} : 24'd0;
         checks++;
         if ({freq, write_en, busy, sfx_id} !== exp) begin
            errors++; $display("FAIL hold t%0d: got %h want %h", t, {freq, write_en, busy, sfx_id}, exp);
         end
      end
      ev_key = 0;
      @(negedge clk); ev_key = 1;
      @(negedge clk); ev_key = 0;
      @(negedge clk);
      @(negedge clk);
      exp = {20'd56818, 1'b1, 1'b1, 2'd0}; checks++;
      if ({freq, write_en, busy, sfx_id} !== exp) begin
         errors++; $display("FAIL pre_reset_note: got %h want %h", {freq, write_en, busy, sfx_id}, exp);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({freq, write_en, busy, sfx_id} !== 24'd0) begin
         errors++; $display("FAIL async_reset: got %h want 0", {freq, write_en, busy, sfx_id});
      end
      @(negedge clk); reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      ev_key = 0; ev_land = 0; ev_row = 0; ev_lose = 0;
      test_reset();
      test_key();
      test_row();
      test_simultaneous();
      test_preempt();
      test_back_to_back();
      test_hold_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
